// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin scheduler sharing one 32-bit add/sub unit; optional ADDSUB_ARB_STATS_EN grant counters
module addsub_arbiter #(
   parameter int N_REQ = 4,
   parameter int LAT   = 1,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [32*N_REQ-1:0]  req_a,
   input  logic [32*N_REQ-1:0]  req_b,
   input  logic [N_REQ-1:0]     req_sub,
   output logic [31:0]          au_in1,
   output logic [31:0]          au_in2,
   output logic                 au_add_sub,
   input  logic [31:0]          au_sum,
   input  logic                 au_c32,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [31:0]          rsp_sum,
   output logic                 rsp_c32
`ifdef ADDSUB_ARB_STATS_EN
   ,
   input  logic [ID_W-1:0]      stat_sel,
   output logic [15:0]          stat_cnt
`endif
);

   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t           state_q;
   logic [ID_W-1:0]  ptr_q;
   logic [ID_W-1:0]  ptr_d;
   logic [CNT_W-1:0] cnt_q;
   logic             grant_found;
   logic [ID_W-1:0]  grant_idx;
   logic [ID_W:0]    scan_idx;
   logic [31:0]      sel_a;
   logic [31:0]      sel_b;
   logic             sel_sub;
   logic             accept;

   // Round-robin search starting at the pointer and wrapping; first valid requester wins
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (scan_idx >= (ID_W+1)'(N_REQ)) begin
            scan_idx = scan_idx - (ID_W+1)'(N_REQ);
         end
         if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx[ID_W-1:0];
         end
      end
   end

   // One-hot ready only while idle and out of reset; operand select and next pointer follow the winner
   always_comb begin
      req_ready = '0;
      sel_a     = '0;
      sel_b     = '0;
      sel_sub   = 1'b0;
      if (rst_n && state_q == IDLE && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_a   = req_a[32*i +: 32];
            sel_b   = req_b[32*i +: 32];
            sel_sub = req_sub[i];
         end
      end
      ptr_d = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
   end

   assign accept = (state_q == IDLE) && grant_found;

   // Main FSM: latch the winner's operands, wait out the unit latency, hold the response until taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         au_in1     <= '0;
         au_in2     <= '0;
         au_add_sub <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_sum    <= '0;
         rsp_c32    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  au_in1     <= sel_a;
                  au_in2     <= sel_b;
                  au_add_sub <= sel_sub;
                  rsp_id     <= grant_idx;
                  ptr_q      <= ptr_d;
                  cnt_q      <= CNT_W'(LAT-1);
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q == '0) begin
                  rsp_sum   <= au_sum;
                  rsp_c32   <= au_c32;
                  rsp_valid <= 1'b1;
                  state_q   <= RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef ADDSUB_ARB_STATS_EN
   logic [15:0] stat_q [N_REQ];

   // Saturating per-requester grant counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REQ; i++) begin
            stat_q[i] <= '0;
         end
      end else if (accept && stat_q[grant_idx] != 16'hFFFF) begin
         stat_q[grant_idx] <= stat_q[grant_idx] + 16'd1;
      end
   end

   // Counter readback; out-of-range selects read as zero
   always_comb begin
      stat_cnt = '0;
      if ({1'b0, stat_sel} < (ID_W+1)'(N_REQ)) begin
         stat_cnt = stat_q[stat_sel];
      end
   end
`endif

endmodule
